// File: rtl/agu_pkg.sv
// Shared types and helpers for the pipelined address generation unit.
// DATA_WIDTH falls back to 32 when the build does not define it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package agu_pkg;

  localparam int AGU_DATA_WIDTH = `DATA_WIDTH;
  localparam int AGU_TAG_WIDTH  = 6;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_t;

  typedef struct packed {
    logic [AGU_DATA_WIDTH-1:0] addr;
    mem_size_t                 size;
    logic [AGU_TAG_WIDTH-1:0]  tag;
  } agu_req_t;

  // Reserved size behaves like a word access.
  function automatic logic misalign(input mem_size_t size, input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lsb[0];
      default:   bad = |lsb;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/agu_if.sv
// Request/response bundle between issue, the AGU and the load-store queue.
// Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on ready.
interface agu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_op1;
  logic [DATA_WIDTH-1:0] in_op2;
  logic [1:0]            in_size;
  logic [TAG_WIDTH-1:0]  in_tag;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_addr;
  logic [1:0]            out_size;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_misalign;

  modport master (
    output in_valid, in_op1, in_op2, in_size, in_tag, out_ready,
    input  in_ready, out_valid, out_addr, out_size, out_tag, out_misalign
  );

  modport slave (
    input  in_valid, in_op1, in_op2, in_size, in_tag, out_ready,
    output in_ready, out_valid, out_addr, out_size, out_tag, out_misalign
  );
endinterface

// File: rtl/agu_stage.sv
// One valid/ready register slice; payload only captures on a real load of valid data.
module agu_stage
  import agu_pkg::*;
#(
  parameter type req_t = agu_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic load,
  input  logic in_valid,
  input  req_t d,
  output logic valid,
  output req_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (flush)
        valid <= 1'b0;
      else if (load)
        valid <= in_valid;
      if (load && in_valid)
        q <= d;
    end
  end

endmodule

// File: rtl/agu_pipe.sv
// Two-stage stallable, flushable effective-address pipeline (addr = base + offset).
// Optional misalign flagging is enabled with AGU_MISALIGN_CHECK_EN.
module agu_pipe
  import agu_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int TAG_WIDTH  = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  agu_if.slave bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    mem_size_t             size;
    logic [TAG_WIDTH-1:0]  tag;
  } req_t;

  req_t s1_d, s1_q, s2_q;
  logic s1_valid, s2_valid;
  logic s1_load, s2_load;
  logic accept;

  // S2 drains whenever the consumer takes it; S1 may then move up behind it.
  assign s2_load = !s2_valid || bus.out_ready;
  assign s1_load = !s1_valid || s2_load;
  assign bus.in_ready = !flush && s1_load;
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    s1_d      = '0;
    s1_d.addr = bus.in_op1 + bus.in_op2;
    s1_d.size = mem_size_t'(bus.in_size);
    s1_d.tag  = bus.in_tag;
  end

  agu_stage #(.req_t(req_t)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .load     (s1_load),
    .in_valid (accept),
    .d        (s1_d),
    .valid    (s1_valid),
    .q        (s1_q)
  );

  agu_stage #(.req_t(req_t)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .load     (s2_load),
    .in_valid (s1_valid),
    .d        (s1_q),
    .valid    (s2_valid),
    .q        (s2_q)
  );

`ifdef AGU_MISALIGN_CHECK_EN
  logic s2_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      s2_misalign <= 1'b0;
    else if (s2_load && s1_valid)
      s2_misalign <= misalign(s1_q.size, s1_q.addr[1:0]);
  end

  assign bus.out_misalign = s2_misalign;
`else
  assign bus.out_misalign = 1'b0;
`endif

  assign bus.out_valid = s2_valid;
  assign bus.out_addr  = s2_q.addr;
  assign bus.out_size  = s2_q.size;
  assign bus.out_tag   = s2_q.tag;

endmodule

// File: tb/tb_agu_pipe.sv
// Self-checking bench for agu_pipe: scenario tasks plus an in-order expected queue.
module tb_agu_pipe;
  import agu_pkg::*;

  localparam int DW = 32;
  localparam int TW = 6;
  localparam int EW = DW + 2 + TW + 1;

  logic clk;
  logic rst;
  logic flush;

  agu_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  agu_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  logic [EW-1:0] exp_q[$];
  int n_vec;
  int n_err;
  int n_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model_mis(input logic [1:0] size, input logic [DW-1:0] addr);
`ifdef AGU_MISALIGN_CHECK_EN
    if (size == 2'b00) return 1'b0;
    if (size == 2'b01) return addr[0];
    return addr[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [EW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [1:0] s, input logic [TW-1:0] t);
    logic [DW-1:0] sum;
    sum = a + b;
    return {sum, s, t, model_mis(s, sum)};
  endfunction

  // Output monitor: every delivered beat is checked against the head of the queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      logic [EW-1:0] got, exp;
      got = {bus.out_addr, bus.out_size, bus.out_tag, bus.out_misalign};
      n_vec++;
      n_out++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got addr=%h tag=%0d, required no output", bus.out_addr, bus.out_tag);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL out_beat: got addr=%h size=%0d tag=%0d mis=%0b, required addr=%h size=%0d tag=%0d mis=%0b",
                   got[EW-1 -: DW], got[TW+2:TW+1], got[TW:1], got[0],
                   exp[EW-1 -: DW], exp[TW+2:TW+1], exp[TW:1], exp[0]);
        end
      end
    end
    if (flush) exp_q.delete();
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [1:0] s, input logic [TW-1:0] t);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op1 = a;
    bus.in_op2 = b;
    bus.in_size = s;
    bus.in_tag = t;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model(a, b, s, t));
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL send_timeout: tag=%0d accepted=0, required 1", t);
    end
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      k++;
      if (bus.out_valid) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int left);
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    left = exp_q.size();
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_addr !== '0 || bus.out_size !== 2'b00 ||
        bus.out_tag !== '0 || bus.out_misalign !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%0b addr=%h size=%0d tag=%0d mis=%0b, required all 0",
               bus.out_valid, bus.out_addr, bus.out_size, bus.out_tag, bus.out_misalign);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %0b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int k, left;
    bus.out_ready = 1'b1;
    send(32'h0000_1000, 32'hFFFF_FFFC, 2'b10, 6'd5);
    wait_valid(k);
    n_vec++;
    if (k !== 2) begin
      n_err++;
      $display("FAIL basic_latency: got %0d cycles, required 2", k);
    end
    drain(left);
    n_vec++;
    if (left !== 0) begin
      n_err++;
      $display("FAIL basic_drain: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_wrap();
    int left;
    bus.out_ready = 1'b1;
    send(32'hFFFF_FFFE, 32'h0000_0004, 2'b01, 6'd7);
    send(32'hFFFF_FFFE, 32'h0000_0004, 2'b10, 6'd8);
    send(32'h0000_0003, 32'h0000_0000, 2'b00, 6'd9);
    send(32'h0000_0011, 32'h0000_0000, 2'b11, 6'd10);
    drain(left);
    n_vec++;
    if (left !== 0) begin
      n_err++;
      $display("FAIL wrap_drain: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_backpressure();
    int base, left;
    base = n_out;
    bus.out_ready = 1'b0;
    send($urandom, $urandom, 2'($urandom_range(0, 3)), 6'd1);
    send($urandom, $urandom, 2'($urandom_range(0, 3)), 6'd2);
    bus.in_valid = 1'b1;
    bus.in_op1 = $urandom;
    bus.in_op2 = $urandom;
    bus.in_size = 2'b10;
    bus.in_tag = 6'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_tag !== 6'd1) begin
        n_err++;
        $display("FAIL bp_hold: got in_ready=%0b out_valid=%0b out_tag=%0d, required 0 1 1",
                 bus.in_ready, bus.out_valid, bus.out_tag);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(bus.in_op1, bus.in_op2, bus.in_size, 6'd3);
    drain(left);
    n_vec++;
    if (left !== 0 || n_out - base !== 3) begin
      n_err++;
      $display("FAIL bp_order: got pending=%0d delivered=%0d, required 0 3", left, n_out - base);
    end
  endtask

  task automatic test_back_to_back();
    int cnt, gap, left;
    logic seen;
    logic [DW-1:0] a, b;
    logic [1:0] s;
    cnt = 0;
    gap = 0;
    seen = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      s = 2'($urandom_range(0, 3));
      bus.in_valid = 1'b1;
      bus.in_op1 = a;
      bus.in_op2 = b;
      bus.in_size = s;
      bus.in_tag = 6'(20 + i);
      @(negedge clk);
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_in_ready: beat %0d got %0b, required 1", i, bus.in_ready);
      end else begin
        exp_q.push_back(model(a, b, s, 6'(20 + i)));
      end
      if (bus.out_valid) begin
        cnt++;
        seen = 1'b1;
      end else if (seen) begin
        gap++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
      else break;
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (cnt !== 8 || gap !== 0) begin
      n_err++;
      $display("FAIL b2b_stream: got %0d valid cycles gap=%0d, required 8 gap=0", cnt, gap);
    end
    drain(left);
    n_vec++;
    if (left !== 0) begin
      n_err++;
      $display("FAIL b2b_drain: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_flush();
    int k, left;
    bus.out_ready = 1'b0;
    send(32'h100, 32'h4, 2'b10, 6'd40);
    send(32'h200, 32'h8, 2'b10, 6'd41);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op1 = 32'h300;
    bus.in_op2 = 32'h0;
    bus.in_size = 2'b00;
    bus.in_tag = 6'd42;
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_in_ready: got %0b, required 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_out_valid: got %0b, required 0", bus.out_valid);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(32'h0000_8000, 32'hFFFF_FFF0, 2'b01, 6'd43);
    wait_valid(k);
    n_vec++;
    if (k !== 2) begin
      n_err++;
      $display("FAIL flush_restart_latency: got %0d cycles, required 2", k);
    end
    drain(left);
    n_vec++;
    if (left !== 0) begin
      n_err++;
      $display("FAIL flush_drain: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    send(32'h1234_5678, 32'h1, 2'b01, 6'd50);
    send(32'h2345_6789, 32'h2, 2'b10, 6'd51);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_addr !== '0 || bus.out_size !== 2'b00 ||
        bus.out_tag !== '0 || bus.out_misalign !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got v=%0b addr=%h size=%0d tag=%0d mis=%0b, required all 0",
               bus.out_valid, bus.out_addr, bus.out_size, bus.out_tag, bus.out_misalign);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: got in_ready=%0b out_valid=%0b, required 1 0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_out = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op1 = '0;
    bus.in_op2 = '0;
    bus.in_size = 2'b00;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
